// File: rtl/spike_event_encoder.sv
// -----------------------------------------------------------------------------
// spike_event_encoder
//
// Turns rising edges of a neuron spike flag into timestamped event words and
// buffers them in a small FIFO for a downstream consumer.
//
// Optional feature macro: SPIKE_EVT_TS_EN
//   defined   : a free-running TS_WIDTH-bit counter supplies the timestamp field
//   undefined : no counter is built; the timestamp field of every event is zero
//
// Parameters
//   FIFO_DEPTH : event buffer depth in entries (power of two, 2..16)
//   TS_WIDTH   : timestamp width in bits
//
// Ports
//   clk        in   single clock, rising-edge
//   rst        in   asynchronous active-high reset
//   spike_in   in   neuron spike flag (may be held high for several cycles)
//   state_in   in   8-bit membrane state, captured with the spike edge
//   out_valid  out  head event available (fifo_level != 0)
//   out_ready  in   consumer accepts the head event
//   out_data   out  head event {timestamp, state}; zero while empty
//   fifo_level out  current number of buffered events
//   overflow   out  sticky: an event was dropped because the FIFO was full
//
// Handshake: a head event transfers on every rising clk edge where
// out_valid=1 and out_ready=1; out_data holds steady while out_valid=1 and
// out_ready=0, and out_ready is ignored while the FIFO is empty.
// -----------------------------------------------------------------------------
module spike_event_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TS_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          spike_in,
    input  logic [7:0]                    state_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TS_WIDTH+7:0]           out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EVT_W = TS_WIDTH + 8;

    logic                 spike_q;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [EVT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]  ts_cur;

    logic evt_detect;
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;

`ifdef SPIKE_EVT_TS_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running; natural binary wrap from all-ones back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + TS_WIDTH'(1);
    end

    assign ts_cur = ts_q;
`else
    assign ts_cur = '0;
`endif

    // One event per low-to-high transition; spike_q resets low so a spike
    // already high on the first cycle after reset still counts.
    assign evt_detect = spike_in & ~spike_q;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign do_pop     = ~fifo_empty & out_ready;
    // A full FIFO still accepts the new event when the head leaves in the
    // same cycle, so level stays at depth and nothing is lost.
    assign do_push    = evt_detect & (~fifo_full | do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (evt_detect && !do_push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            spike_q    <= spike_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: every read is gated by fifo_empty below.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {ts_cur, state_in};
    end

    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_event_encoder
//
// Directed bench for spike_event_encoder (FIFO_DEPTH=4, TS_WIDTH=8).
// Inputs are driven just after each falling edge; outputs are compared at the
// following falling edge, i.e. after the rising edge that consumed the inputs.
// The expected timestamp field is the bench's own cycle count since reset
// release, or zero when SPIKE_EVT_TS_EN is not defined.
// -----------------------------------------------------------------------------
module tb_spike_event_encoder;

    logic        clk;
    logic        rst;
    logic        spike_in;
    logic [7:0]  state_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  fifo_level;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tb_ts;
    logic [15:0] exp_q[$];

    spike_event_encoder #(
        .FIFO_DEPTH (4),
        .TS_WIDTH   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .state_in   (state_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side cycle count since reset release (expected timestamp source).
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= 8'd0;
        else     tb_ts <= tb_ts + 8'd1;
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] tsx(input logic [7:0] t);
`ifdef SPIKE_EVT_TS_EN
        return t;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge consume them, return at
    // the next falling edge with the post-edge state visible.
    task automatic cycle(input logic sp, input logic [7:0] st, input logic rdy);
        spike_in  = sp;
        state_in  = st;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns at a falling edge with reset just released and tb_ts == 0.
    task automatic do_reset();
        spike_in  = 1'b0;
        state_in  = 8'h00;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [2:0] lvl,
                             input logic ov, input logic [15:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".level"}, 32'(fifo_level), 32'(lvl));
        chk({tag, ".ovf"},   32'(overflow), 32'(ov));
        chk({tag, ".data"},  32'(out_data), 32'(d));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       spike;
        logic [7:0] state;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_level;
        logic       exp_ovf;
        logic [7:0] exp_ts;
        logic [7:0] exp_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sp, input logic [7:0] st, input logic rdy,
                       input logic v, input logic [2:0] lvl, input logic ov,
                       input logic [7:0] ts, input logic [7:0] est);
        vec_t r;
        r.spike = sp; r.state = st; r.ready = rdy;
        r.exp_valid = v; r.exp_level = lvl; r.exp_ovf = ov;
        r.exp_ts = ts; r.exp_st = est;
        vecs.push_back(r);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [15:0] exp_d;
        bit          found;

        // Row k is driven while the timestamp counter equals k.
        for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 8'h00);
        add(1, 8'h3C, 1, 1, 3'd1, 0, 8'h05, 8'h3C);   // edge at counter 5
        add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 8'h00);   // popped
        add(1, 8'hA5, 0, 1, 3'd1, 0, 8'h07, 8'hA5);   // held-high spike begins
        for (int i = 0; i < 9; i++) add(1, 8'h5A, 0, 1, 3'd1, 0, 8'h07, 8'hA5);
        add(0, 8'h00, 0, 1, 3'd1, 0, 8'h07, 8'hA5);
        add(0, 8'h00, 1, 0, 3'd0, 0, 8'h00, 8'h00);
        add(1, 8'h11, 0, 1, 3'd1, 0, 8'h13, 8'h11);   // five separate spikes
        add(0, 8'h00, 0, 1, 3'd1, 0, 8'h13, 8'h11);
        add(1, 8'h22, 0, 1, 3'd2, 0, 8'h13, 8'h11);
        add(0, 8'h00, 0, 1, 3'd2, 0, 8'h13, 8'h11);
        add(1, 8'h33, 0, 1, 3'd3, 0, 8'h13, 8'h11);
        add(0, 8'h00, 0, 1, 3'd3, 0, 8'h13, 8'h11);
        add(1, 8'h44, 0, 1, 3'd4, 0, 8'h13, 8'h11);
        add(0, 8'h00, 0, 1, 3'd4, 0, 8'h13, 8'h11);
        add(1, 8'h55, 0, 1, 3'd4, 1, 8'h13, 8'h11);   // dropped
        add(0, 8'h00, 0, 1, 3'd4, 1, 8'h13, 8'h11);
        add(0, 8'h00, 1, 1, 3'd3, 1, 8'h15, 8'h22);   // drain
        add(0, 8'h00, 1, 1, 3'd2, 1, 8'h17, 8'h33);
        add(0, 8'h00, 1, 1, 3'd1, 1, 8'h19, 8'h44);
        add(0, 8'h00, 1, 0, 3'd0, 1, 8'h00, 8'h00);
        add(0, 8'h00, 1, 0, 3'd0, 1, 8'h00, 8'h00);   // ready while empty

        do_reset();
        chk_state("reset", 0, 3'd0, 0, 16'h0000);

        foreach (vecs[i]) begin
            exp_d = vecs[i].exp_valid ? {tsx(vecs[i].exp_ts), vecs[i].exp_st} : 16'h0000;
            cycle(vecs[i].spike, vecs[i].state, vecs[i].ready);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_level,
                      vecs[i].exp_ovf, exp_d);
        end

        // ---- full FIFO with simultaneous push and pop; spike at first cycle ----
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({tsx(tb_ts), 8'hA1 + 8'(k)});
            cycle(1, 8'hA1 + 8'(k), 0);
            if (k == 0) chk_state("first_cycle", 1, 3'd1, 0, exp_q[0]);
            cycle(0, 8'h00, 0);
        end
        chk("full.level", 32'(fifo_level), 32'd4);
        void'(exp_q.pop_front());                 // head leaves this cycle
        exp_q.push_back({tsx(tb_ts), 8'hA5});
        cycle(1, 8'hA5, 1);
        chk_state("push_pop_full", 1, 3'd4, 0, exp_q[0]);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d.data", k), 32'(out_data), 32'(exp_q.pop_front()));
            cycle(0, 8'h00, 1);
        end
        chk_state("drained", 0, 3'd0, 0, 16'h0000);

        // ---- timestamp wrap ----
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (tb_ts == 8'd254) found = 1'b1;
            else cycle(0, 8'h00, 0);
        end
        chk("wrap.reach254", 32'(found), 32'd1);
        cycle(1, 8'h77, 0);                        // counter 254
        cycle(0, 8'h00, 0);                        // 255
        cycle(0, 8'h00, 0);                        // 0
        cycle(1, 8'h88, 0);                        // 1
        chk_state("wrap.head", 1, 3'd2, 0, {tsx(8'hFE), 8'h77});
        cycle(0, 8'h00, 1);
        chk_state("wrap.second", 1, 3'd1, 0, {tsx(8'h01), 8'h88});

        // ---- asynchronous reset with entries buffered ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1, 8'h60 + 8'(k), 0);
            cycle(0, 8'h00, 0);
        end
        chk("pre_rst.ovf", 32'(overflow), 32'd1);
        cycle(0, 8'h00, 1);
        chk("pre_rst.level", 32'(fifo_level), 32'd3);
        rst = 1'b1;                                // mid-cycle, away from any edge
        #1;
        chk_state("async_rst", 0, 3'd0, 0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
